// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and constants for the SPI target controller
package spi_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_state_t;
   localparam logic SPI_FILL_BIT = 1'b1;
   localparam logic SPI_CPOL     = 1'b0;
   localparam logic SPI_CPHA     = 1'b0;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop pin synchroniser with rise/fall detection
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);
   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end
   assign o_q    = r_sync[STAGES-1];
   assign o_rise = o_q & ~r_prev;
   assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI mode-0 target with TX holding register and RX valid/ready handshake.
// Define SPI_SLAVE_OVERRUN_DET_EN to drop words on overrun and raise a sticky o_Overrun.
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_SCLK,
   input  logic              i_MOSI,
   input  logic              i_SS,
   output logic              o_MISO,
   output logic              o_MISO_OE,
   input  logic [DATA_W-1:0] i_TX_Data,
   input  logic              i_TX_Valid,
   output logic              o_TX_Ready,
   output logic [DATA_W-1:0] o_RX_Data,
   output logic              o_RX_Valid,
   input  logic              i_RX_Ready,
   output logic              o_Busy,
   output logic              o_Overrun,
   input  logic              i_Clr_Overrun
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
   spi_state_t        r_state;
   logic [DATA_W-1:0] r_tx_sr, r_rx_sr, r_hold, r_rx_data, w_load_word;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_hold_full, r_reload, r_done, r_miso, r_oe, r_rx_valid;
   logic              w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi, w_load;
   logic [3:0]        w_unused_sync;
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_SCLK),
      .o_q(w_unused_sync[0]), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
   // SS resets low so a pin already low after reset cannot look like a frame start
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_SS),
      .o_q(w_unused_sync[1]), .o_rise(w_ss_rise), .o_fall(w_ss_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_MOSI),
      .o_q(w_mosi), .o_rise(w_unused_sync[2]), .o_fall(w_unused_sync[3]));
   assign w_load_word = r_hold_full ? r_hold : (i_TX_Valid ? i_TX_Data : {DATA_W{SPI_FILL_BIT}});
   assign w_load = !w_ss_rise && (r_state == LOAD || (r_state == SHIFT && w_sclk_fall && r_reload));
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_reload <= 1'b0;
         r_done   <= 1'b0;
         r_tx_sr  <= '0;
         r_rx_sr  <= '0;
         r_miso   <= 1'b0;
         r_oe     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_ss_rise) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_reload <= 1'b0;
            r_oe     <= 1'b0;
         end else if (r_state == IDLE) begin
            if (w_ss_fall) r_state <= LOAD;
         end else begin
            if (r_state == LOAD) begin
               r_state <= SHIFT;
               r_cnt   <= '0;
               r_oe    <= 1'b1;
            end else if (w_sclk_rise) begin
               r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_mosi};
               r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_reload <= 1'b1;
                  r_done   <= 1'b1;
               end
            end
            if (w_load) begin
               r_tx_sr  <= w_load_word;
               r_miso   <= w_load_word[DATA_W-1];
               r_reload <= 1'b0;
            end else if (r_state == SHIFT && w_sclk_fall) begin
               r_tx_sr <= r_tx_sr << 1;
               r_miso  <= r_tx_sr[DATA_W-2];
            end
         end
      end
   end
   // an empty register being loaded takes the incoming word straight into the shifter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold_full <= 1'b0;
         r_hold      <= '0;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end else if (i_TX_Valid && !r_hold_full) begin
         r_hold_full <= 1'b1;
         r_hold      <= i_TX_Data;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else if (r_done && r_rx_valid && !i_RX_Ready) begin
`ifndef SPI_SLAVE_OVERRUN_DET_EN
         r_rx_data <= r_rx_sr;
`endif
      end else if (r_done) begin
         r_rx_data  <= r_rx_sr;
         r_rx_valid <= 1'b1;
      end else if (r_rx_valid && i_RX_Ready) begin
         r_rx_valid <= 1'b0;
      end
   end
`ifdef SPI_SLAVE_OVERRUN_DET_EN
   logic r_overrun;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_overrun <= 1'b0;
      else if (r_done && r_rx_valid && !i_RX_Ready) r_overrun <= 1'b1;
      else if (i_Clr_Overrun) r_overrun <= 1'b0;
   end
   assign o_Overrun = r_overrun;
`else
   logic w_unused_clr;
   assign w_unused_clr = i_Clr_Overrun;
   assign o_Overrun    = 1'b0;
`endif
   assign o_MISO     = r_miso;
   assign o_MISO_OE  = r_oe;
   assign o_TX_Ready = !r_hold_full;
   assign o_RX_Data  = r_rx_data;
   assign o_RX_Valid = r_rx_valid;
   assign o_Busy     = r_state != IDLE;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed self-checking bench for spi_slave_ctrl (DATA_W=8, SYNC_STAGES=2)
module tb_spi_slave_ctrl;
   localparam int HALF = 8;
   logic       clk = 0, rst_n = 0, sclk = 0, mosi = 0, ss = 1;
   logic       tx_valid = 0, rx_ready = 1, clr_ov = 0;
   logic [7:0] tx_data = 0;
   logic       o_MISO, o_MISO_OE, o_TX_Ready, o_RX_Valid, o_Busy, o_Overrun;
   logic [7:0] o_RX_Data;
   logic [7:0] rx_q[$];
   int         tests = 0, fails = 0;
   always #5 clk = ~clk;
   spi_slave_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_SCLK(sclk), .i_MOSI(mosi), .i_SS(ss),
      .o_MISO(o_MISO), .o_MISO_OE(o_MISO_OE), .i_TX_Data(tx_data), .i_TX_Valid(tx_valid),
      .o_TX_Ready(o_TX_Ready), .o_RX_Data(o_RX_Data), .o_RX_Valid(o_RX_Valid),
      .i_RX_Ready(rx_ready), .o_Busy(o_Busy), .o_Overrun(o_Overrun), .i_Clr_Overrun(clr_ov));
   always @(posedge clk) if (o_RX_Valid && rx_ready) rx_q.push_back(o_RX_Data);
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic tx_write(input logic [7:0] d);
      tx_data = d;
      tx_valid = 1;
      cyc(1);
      tx_valid = 0;
   endtask
   task automatic xfer_bits(input int n, input logic [7:0] m, output logic [7:0] s);
      s = 0;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = m[i];
         cyc(HALF);
         sclk = 1;
         s = {s[6:0], o_MISO};
         cyc(HALF);
         sclk = 0;
      end
   endtask
   task automatic test_reset();
      cyc(2);
      tests++;
      if ({o_MISO, o_MISO_OE, o_TX_Ready, o_RX_Valid, o_Busy, o_Overrun, o_RX_Data} !== {6'b001000, 8'h00}) begin
         fails++;
         $display("FAIL reset_values got %b_%h exp 001000_00", {o_MISO, o_MISO_OE, o_TX_Ready, o_RX_Valid, o_Busy, o_Overrun}, o_RX_Data);
      end
      rst_n = 1;
      cyc(4);
      tests++;
      if (o_Busy !== 0) begin fails++; $display("FAIL reset_no_frame busy=%b exp 0", o_Busy); end
   endtask
   task automatic test_single_frame();
      int n0 = rx_q.size();
      logic [7:0] g;
      tx_write(8'hA5);
      tests++;
      if (o_TX_Ready !== 0) begin fails++; $display("FAIL single_ready_after_write got %b exp 0", o_TX_Ready); end
      ss = 0;
      cyc(3);
      tests++;
      if ({o_Busy, o_MISO_OE} !== 2'b10) begin fails++; $display("FAIL single_load_timing busy,oe got %b exp 10", {o_Busy, o_MISO_OE}); end
      cyc(1);
      tests++;
      if ({o_MISO_OE, o_MISO, o_TX_Ready} !== 3'b111) begin fails++; $display("FAIL single_msb_timing oe,miso,ready got %b exp 111", {o_MISO_OE, o_MISO, o_TX_Ready}); end
      xfer_bits(8, 8'h3C, g);
      cyc(HALF);
      ss = 1;
      cyc(HALF);
      tests++;
      if (g !== 8'hA5) begin fails++; $display("FAIL single_miso got %h exp a5", g); end
      tests++;
      if (rx_q.size() != n0 + 1 || rx_q[n0] !== 8'h3C) begin fails++; $display("FAIL single_rx count %0d data %h exp 1 3c", rx_q.size() - n0, rx_q[n0]); end
      tests++;
      if ({o_Busy, o_MISO_OE} !== 2'b00) begin fails++; $display("FAIL single_idle busy,oe got %b exp 00", {o_Busy, o_MISO_OE}); end
   endtask
   task automatic test_back_to_back();
      int n0 = rx_q.size();
      logic [7:0] g1, g2;
      tx_write(8'h12);
      ss = 0;
      cyc(HALF);
      tx_write(8'h34);
      tests++;
      if (o_TX_Ready !== 0) begin fails++; $display("FAIL b2b_ready got %b exp 0", o_TX_Ready); end
      xfer_bits(8, 8'h55, g1);
      xfer_bits(8, 8'hAA, g2);
      cyc(HALF);
      ss = 1;
      cyc(HALF);
      tests++;
      if ({g1, g2} !== 16'h1234) begin fails++; $display("FAIL b2b_miso got %h exp 1234", {g1, g2}); end
      tests++;
      if (rx_q.size() != n0 + 2 || {rx_q[n0], rx_q[n0+1]} !== 16'h55AA) begin fails++; $display("FAIL b2b_rx count %0d got %h%h exp 2 55aa", rx_q.size() - n0, rx_q[n0], rx_q[n0+1]); end
   endtask
   task automatic test_underrun();
      int n0 = rx_q.size();
      logic [7:0] g;
      ss = 0;
      cyc(HALF);
      xfer_bits(8, 8'h0F, g);
      cyc(HALF);
      tests++;
      if (o_TX_Ready !== 1) begin fails++; $display("FAIL underrun_ready got %b exp 1", o_TX_Ready); end
      ss = 1;
      cyc(HALF);
      tests++;
      if (g !== 8'hFF) begin fails++; $display("FAIL underrun_miso got %h exp ff", g); end
      tests++;
      if (rx_q.size() != n0 + 1 || rx_q[n0] !== 8'h0F) begin fails++; $display("FAIL underrun_rx count %0d data %h exp 1 0f", rx_q.size() - n0, rx_q[n0]); end
   endtask
   task automatic test_abort();
      int n0 = rx_q.size();
      logic [7:0] g;
      ss = 0;
      cyc(HALF);
      xfer_bits(5, 8'hF0, g);
      cyc(HALF);
      ss = 1;
      cyc(2);
      tests++;
      if (o_MISO_OE !== 1) begin fails++; $display("FAIL abort_oe_early got %b exp 1", o_MISO_OE); end
      cyc(1);
      tests++;
      if ({o_MISO_OE, o_Busy} !== 2'b00) begin fails++; $display("FAIL abort_oe_drop oe,busy got %b exp 00", {o_MISO_OE, o_Busy}); end
      cyc(HALF);
      tests++;
      if (rx_q.size() != n0 || o_RX_Valid !== 0) begin fails++; $display("FAIL abort_no_rx count %0d valid %b exp 0 0", rx_q.size() - n0, o_RX_Valid); end
      ss = 0;
      cyc(HALF);
      xfer_bits(8, 8'h81, g);
      cyc(HALF);
      ss = 1;
      cyc(HALF);
      tests++;
      if (rx_q.size() != n0 + 1 || rx_q[n0] !== 8'h81 || g !== 8'hFF) begin fails++; $display("FAIL abort_next_frame count %0d rx %h miso %h exp 1 81 ff", rx_q.size() - n0, rx_q[n0], g); end
   endtask
   task automatic test_overrun();
      int n0 = rx_q.size();
      logic [7:0] g;
      rx_ready = 0;
      ss = 0;
      cyc(HALF);
      xfer_bits(8, 8'h01, g);
      cyc(HALF);
      tests++;
      if ({o_RX_Valid, o_Overrun, o_RX_Data} !== {2'b10, 8'h01}) begin fails++; $display("FAIL overrun_first valid,ov %b data %h exp 10 01", {o_RX_Valid, o_Overrun}, o_RX_Data); end
      xfer_bits(8, 8'h02, g);
      cyc(HALF);
      ss = 1;
      cyc(HALF);
`ifdef SPI_SLAVE_OVERRUN_DET_EN
      tests++;
      if ({o_RX_Valid, o_Overrun, o_RX_Data} !== {2'b11, 8'h01}) begin fails++; $display("FAIL overrun_second valid,ov %b data %h exp 11 01", {o_RX_Valid, o_Overrun}, o_RX_Data); end
      cyc(3);
      tests++;
      if (o_Overrun !== 1) begin fails++; $display("FAIL overrun_sticky got %b exp 1", o_Overrun); end
`else
      tests++;
      if ({o_RX_Valid, o_Overrun, o_RX_Data} !== {2'b10, 8'h02}) begin fails++; $display("FAIL overrun_second valid,ov %b data %h exp 10 02", {o_RX_Valid, o_Overrun}, o_RX_Data); end
`endif
      clr_ov = 1;
      cyc(1);
      clr_ov = 0;
      tests++;
      if (o_Overrun !== 0) begin fails++; $display("FAIL overrun_clear got %b exp 0", o_Overrun); end
      rx_ready = 1;
      cyc(1);
      tests++;
      if (o_RX_Valid !== 0 || rx_q.size() != n0 + 1) begin fails++; $display("FAIL overrun_consume valid %b count %0d exp 0 1", o_RX_Valid, rx_q.size() - n0); end
   endtask
   task automatic test_reset_mid_word();
      int n0;
      logic [7:0] g;
      tx_write(8'h5A);
      ss = 0;
      cyc(HALF);
      xfer_bits(4, 8'hFF, g);
      cyc(2);
      rst_n = 0;
      #1;
      tests++;
      if ({o_MISO, o_MISO_OE, o_TX_Ready, o_RX_Valid, o_Busy, o_Overrun, o_RX_Data} !== {6'b001000, 8'h00}) begin
         fails++;
         $display("FAIL midreset_values got %b_%h exp 001000_00", {o_MISO, o_MISO_OE, o_TX_Ready, o_RX_Valid, o_Busy, o_Overrun}, o_RX_Data);
      end
      cyc(2);
      rst_n = 1;
      n0 = rx_q.size();
      cyc(HALF);
      xfer_bits(8, 8'h99, g);
      cyc(HALF);
      tests++;
      if ({o_Busy, o_MISO_OE} !== 2'b00 || rx_q.size() != n0) begin fails++; $display("FAIL midreset_no_start busy,oe %b count %0d exp 00 0", {o_Busy, o_MISO_OE}, rx_q.size() - n0); end
      ss = 1;
      cyc(HALF);
      ss = 0;
      cyc(HALF);
      xfer_bits(8, 8'hC3, g);
      cyc(HALF);
      ss = 1;
      cyc(HALF);
      tests++;
      if (rx_q.size() != n0 + 1 || rx_q[n0] !== 8'hC3) begin fails++; $display("FAIL midreset_next_frame count %0d data %h exp 1 c3", rx_q.size() - n0, rx_q[n0]); end
   endtask
   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_overrun();
      test_reset_mid_word();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI target (slave) controller: the far end of the SPI link driven by the team's SPI master, for use in ECU peripherals that are addressed by a master over SCLK/MOSI/MISO/SS. It oversamples the external SPI pins in the system clock domain and deserialises MOSI into parallel words. It serialises queued TX words onto MISO, supports back-to-back words while SS stays asserted, and presents parallel valid/ready handshakes to local logic.

## Interface
- DATA_W, 8: word width in bits; MSB first on the wire.
- SYNC_STAGES, 2: synchroniser flops per input pin; minimum 2.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_SCLK, i_MOSI, i_SS  in  1 each  raw SPI pins; SS is active low.
- o_MISO  out  1  serial data to master; reset 0.
- o_MISO_OE  out  1  MISO tristate enable; reset 0.
- i_TX_Data  in  DATA_W  next word to transmit.
- i_TX_Valid  in  1 / o_TX_Ready  out  1  TX handshake; o_TX_Ready resets to 1.
- o_RX_Data  out  DATA_W  last received word; reset 0.
- o_RX_Valid  out  1 / i_RX_Ready  in  1  RX handshake; o_RX_Valid resets to 0.
- o_Busy  out  1  a frame is in progress (state != IDLE); reset 0.
- o_Overrun  out  1 / i_Clr_Overrun  in  1  sticky overrun flag and its clear; o_Overrun resets to 0.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0):
  - Master samples on SCLK rise and changes data on SCLK fall.
  - This block samples MOSI on the synced rise and updates MISO on the synced fall.
- Synchroniser reset values: SCLK = 0, SS = 0. The SS reset value suppresses a false frame start; a frame starts only on a synced SS 1→0 edge.
- TX holding register (one entry):
  - Written on i_TX_Valid && o_TX_Ready.
  - o_TX_Ready = holding register empty.
  - The register empties when its word moves into the TX shift register.
- States:
  - IDLE: o_MISO_OE=0. Synced SS fall → LOAD.
  - LOAD (1 cycle): TX shift register ← holding word, or all-ones if the holding register is empty (underrun fill). o_MISO ← MSB, o_MISO_OE=1, bit count ← 0. Go to SHIFT.
  - SHIFT:
    - Synced SCLK rise: rx_sr ← {rx_sr[DATA_W-2:0], MOSI}, count++.
    - Rise with count == DATA_W-1: word complete, count ← 0, set the reload flag.
    - Synced SCLK fall with reload flag set: load the next word, as in LOAD. Otherwise shift TX left and drive the new MSB.
- Synced SS rise in any state → IDLE:
  - Partial RX word discarded; partial TX word lost.
  - Count and reload flag cleared; o_MISO_OE=0 in the same cycle.
- Word complete with o_RX_Valid=0: o_RX_Data ← received word, o_RX_Valid ← 1.
- o_RX_Valid clears on o_RX_Valid && i_RX_Ready. Word complete and consume in the same cycle: the new word loads and o_RX_Valid stays 1.
- Word complete with o_RX_Valid=1 and no consume: overrun. Behaviour depends on Configuration.
- Simultaneous TX write and LOAD on an empty holding register: the incoming word loads directly into the shift register and o_TX_Ready stays 1.

## Timing
- Pin-to-event latency: SYNC_STAGES + 1 i_clk cycles (synchroniser plus edge-detect flop).
- Requirements on the master:
  - SCLK high and low phases each ≥ SYNC_STAGES+3 i_clk cycles.
  - SS fall to first SCLK rise ≥ SYNC_STAGES+3 cycles.
  - Last SCLK fall to SS rise ≥ 1 SCLK half-period.
- MSB is valid on MISO SYNC_STAGES+2 cycles after the SS pin falls.
- o_RX_Valid asserts SYNC_STAGES+2 cycles after the last SCLK rise at the pin.
- i_rst_n low: all registers are forced to their reset values asynchronously. The block does not restart mid-frame; it waits for the next SS high→low.

## Configuration
- SPI_SLAVE_OVERRUN_DET_EN defined:
  - On overrun the new word is dropped, o_RX_Data keeps the old word, and o_Overrun is set.
  - o_Overrun stays set until i_Clr_Overrun. If set and clear occur in the same cycle, set wins.
- SPI_SLAVE_OVERRUN_DET_EN undefined:
  - The new word overwrites o_RX_Data and o_RX_Valid stays 1.
  - o_Overrun is tied to 0 and i_Clr_Overrun is ignored.

## Structure
- Package spi_pkg holds:
  - the state enum typedef (IDLE, LOAD, SHIFT);
  - the underrun fill-pattern constant;
  - the SPI mode constant (CPOL=0, CPHA=0).
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser with a parameterised reset value, plus o_rise/o_fall detection. Instantiated for SCLK and SS; for MOSI only the synchronised output is used.

## Test plan
- Single frame (DATA_W=8): TX 0xA5 preloaded, master sends 0x3C → o_RX_Data=0x3C with one valid handshake; master captures 0xA5.
- Back-to-back: 0x12 preloaded, 0x34 written during word 1, SS held low for 16 bits; master sends 0x55, 0xAA → master reads 0x12, 0x34; RX yields 0x55 then 0xAA.
- Underrun: TX never written, master sends 0x0F → MISO shifts 0xFF; o_TX_Ready stays 1.
- SS abort after 5 bits, then a full frame sending 0x81:
  - No o_RX_Valid for the partial word.
  - o_MISO_OE drops SYNC_STAGES+1 cycles after the SS rise.
  - The following frame receives 0x81 correctly.
- Overrun: i_RX_Ready held 0, words 0x01 then 0x02 → with the macro, o_RX_Data=0x01 and o_Overrun=1 until i_Clr_Overrun; without it, o_RX_Data=0x02 and o_Overrun=0.
- Reset mid-word (bit 4) with SS held low:
  - All outputs take reset values immediately.
  - No frame starts until SS toggles high then low.
  - The next 0xC3 frame is received correctly.
